// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: default geometry, FSM state
// encoding and address helpers.
package icache_pkg;

    // Default number of index bits; 2^ICACHE_IDX_W direct-mapped lines.
    localparam int ICACHE_IDX_W = 4;

    // Request-handling states of the cache controller.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // waiting for start_fetch, lookup is combinational on pc
        MISS  = 2'd1,  // refill outstanding, response owed to the fetcher
        RESP  = 2'd2,  // single cycle in which instr_ready is high
        DRAIN = 2'd3   // refill outstanding, request abandoned by rob_clear
    } state_e;

    // Word-aligned form of a byte address (low two bits forced to zero).
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped storage: valid/tag/data per line, combinational read port,
// synchronous write port. Only the valid bits are cleared by reset.
module icache_array
    import icache_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W,
    localparam int TAG_W = 30 - IDX_W,
    localparam int LINES = 1 << IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             hit_o,
    output logic [31:0]      rd_data_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Valid bits: cleared on reset, set when a line is filled.
    // NOTE: non-blocking (<=) in every clocked block so all registers update
    // together from values sampled at the same edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data payload: written on fill.
    // NOTE: no reset on the tag/data arrays; a cleared valid bit already makes
    // their contents don't-care, and leaving them unreset lets them map to RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Combinational lookup.
    assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Instruction cache, responder side of the fetch interface. Hits answer one
// cycle after the request; misses refill one word through the arbiter's
// read port and answer in the cycle after mem_rd_done.
module icache
    import icache_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        rob_clear,
    input  logic        start_fetch,
    input  logic [31:0] pc,
    output logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_addr,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_done,
    input  logic [31:0] mem_rd_data
);

    localparam int TAG_W = 30 - IDX_W;

    state_e      state_q, state_d;
    logic        instr_ready_q, instr_ready_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_addr_q, instr_addr_d;
    logic        mem_rd_req_q, mem_rd_req_d;
    logic [31:0] mem_rd_addr_q, mem_rd_addr_d;

    logic        hit;
    logic [31:0] rd_data;
    logic        fill;

    // pc[1:0] carries no information for word fetches.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc[1:0];

    // Lookup uses the live pc; the fill uses the latched refill address.
    icache_array #(.IDX_W(IDX_W)) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx_i  (pc[IDX_W+1:2]),
        .rd_tag_i  (pc[31:IDX_W+2]),
        .hit_o     (hit),
        .rd_data_o (rd_data),
        .we_i      (fill && rdy),
        .wr_idx_i  (mem_rd_addr_q[IDX_W+1:2]),
        .wr_tag_i  (mem_rd_addr_q[31:TAG_W'(IDX_W+2)]),
        .wr_data_i (mem_rd_data)
    );

    // Next-state and next-output logic; rob_clear takes priority over everything.
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        instr_ready_d = 1'b0;
        instr_d       = '0;
        instr_addr_d  = '0;
        mem_rd_req_d  = mem_rd_req_q;
        mem_rd_addr_d = mem_rd_addr_q;
        fill          = 1'b0;

        case (state_q)
            IDLE: begin
                if (rob_clear) begin
                    state_d = IDLE;
                end else if (start_fetch) begin
                    if (hit) begin
                        instr_ready_d = 1'b1;
                        instr_d       = rd_data;
                        instr_addr_d  = word_addr(pc);
                        state_d       = RESP;
                    end else begin
                        mem_rd_req_d  = 1'b1;
                        mem_rd_addr_d = word_addr(pc);
                        state_d       = MISS;
                    end
                end
            end
            MISS: begin
                if (mem_rd_done) begin
                    fill         = 1'b1;
                    mem_rd_req_d = 1'b0;
                    if (rob_clear) begin
                        state_d = IDLE;
                    end else begin
                        instr_ready_d = 1'b1;
                        instr_d       = mem_rd_data;
                        instr_addr_d  = mem_rd_addr_q;
                        state_d       = RESP;
                    end
                end else if (rob_clear) begin
                    state_d = DRAIN;
                end
            end
            RESP: begin
                // start_fetch is still high here from the request just served.
                state_d = IDLE;
            end
            DRAIN: begin
                if (mem_rd_done) begin
                    fill         = 1'b1;
                    mem_rd_req_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; rdy=0 freezes all of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            instr_ready_q <= 1'b0;
            instr_q       <= '0;
            instr_addr_q  <= '0;
            mem_rd_req_q  <= 1'b0;
            mem_rd_addr_q <= '0;
        end else if (rdy) begin
            state_q       <= state_d;
            instr_ready_q <= instr_ready_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_rd_addr_q <= mem_rd_addr_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign instr       = instr_q;
    assign instr_addr  = instr_addr_q;
    assign mem_rd_req  = mem_rd_req_q;
    assign mem_rd_addr = mem_rd_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a cycle-by-cycle vector table plus
// hand-written sequences for rdy freeze and asynchronous reset.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        rob_clear;
    logic        start_fetch;
    logic [31:0] pc;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_done;
    logic [31:0] mem_rd_data;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] D1 = 32'h0051_0113;
    localparam logic [31:0] D2 = 32'hAAAA_0050;
    localparam logic [31:0] D3 = 32'h1234_5678;
    localparam logic [31:0] D4 = 32'hCAFE_0200;
    localparam logic [31:0] D5 = 32'h0000_0014;
    localparam logic [31:0] D6 = 32'h0000_0018;

    icache dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .rob_clear   (rob_clear),
        .start_fetch (start_fetch),
        .pc          (pc),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_addr  (instr_addr),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_done (mem_rd_done),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus and the outputs expected just after the edge.
    typedef struct {
        logic        rdy;
        logic        rc;
        logic        sf;
        logic [31:0] pc;
        logic        dn;
        logic [31:0] dat;
        logic        erd;
        logic [31:0] eins;
        logic [31:0] eia;
        logic        erq;
        logic [31:0] era;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rdy_v, input logic rc, input logic sf,
                                input logic [31:0] pc_v, input logic dn,
                                input logic [31:0] dat, input logic erd,
                                input logic [31:0] eins, input logic [31:0] eia,
                                input logic erq, input logic [31:0] era);
        vec_t v;
        v.rdy = rdy_v; v.rc = rc; v.sf = sf; v.pc = pc_v; v.dn = dn; v.dat = dat;
        v.erd = erd; v.eins = eins; v.eia = eia; v.erq = erq; v.era = era;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic erd, input logic [31:0] eins,
                             input logic [31:0] eia, input logic erq, input logic [31:0] era);
        check({tag, " instr_ready"}, {31'b0, instr_ready}, {31'b0, erd});
        check({tag, " instr"},       instr,                eins);
        check({tag, " instr_addr"},  instr_addr,           eia);
        check({tag, " mem_rd_req"},  {31'b0, mem_rd_req},  {31'b0, erq});
        check({tag, " mem_rd_addr"}, mem_rd_addr,          era);
    endtask

    // Advance one clock and land just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy_v, input logic rc, input logic sf,
                         input logic [31:0] pc_v, input logic dn, input logic [31:0] dat);
        rdy = rdy_v; rob_clear = rc; start_fetch = sf; pc = pc_v;
        mem_rd_done = dn; mem_rd_data = dat;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Cold miss on 0x10, refill after 5 cycles.
        add(1,0,1,32'h10,0,0,  0,0,0,1,32'h10);
        for (int i = 0; i < 4; i++) add(1,0,1,32'h10,0,0, 0,0,0,1,32'h10);
        add(1,0,1,32'h10,1,D1, 1,D1,32'h10,0,32'h10);
        add(1,0,1,32'h10,0,0,  0,0,0,0,32'h10);
        add(1,0,0,32'h10,0,0,  0,0,0,0,32'h10);
        // Hit after fill; start_fetch held through the pulse cycle -> one pulse.
        add(1,0,1,32'h10,0,0,  1,D1,32'h10,0,32'h10);
        add(1,0,1,32'h10,0,0,  0,0,0,0,32'h10);
        add(1,0,0,32'h10,0,0,  0,0,0,0,32'h10);
        // Conflict on index 4: 0x50 evicts 0x10, then 0x10 misses again.
        add(1,0,1,32'h50,0,0,  0,0,0,1,32'h50);
        add(1,0,1,32'h50,1,D2, 1,D2,32'h50,0,32'h50);
        add(1,0,1,32'h50,0,0,  0,0,0,0,32'h50);
        add(1,0,1,32'h10,0,0,  0,0,0,1,32'h10);
        add(1,0,1,32'h10,1,D1, 1,D1,32'h10,0,32'h10);
        add(1,0,0,32'h10,0,0,  0,0,0,0,32'h10);
        // Clear during miss: drain, no pulse, line still filled.
        add(1,0,1,32'h100,0,0,  0,0,0,1,32'h100);
        add(1,0,1,32'h100,0,0,  0,0,0,1,32'h100);
        add(1,1,0,32'h100,0,0,  0,0,0,1,32'h100);
        add(1,0,0,32'h100,0,0,  0,0,0,1,32'h100);
        add(1,0,0,32'h100,0,0,  0,0,0,1,32'h100);
        add(1,0,0,32'h100,1,D3, 0,0,0,0,32'h100);
        add(1,0,1,32'h100,0,0,  1,D3,32'h100,0,32'h100);
        add(1,0,0,32'h100,0,0,  0,0,0,0,32'h100);
        // Clear together with a hit: suppressed; next pc served normally.
        add(1,1,1,32'h10,0,0,   0,0,0,0,32'h100);
        add(1,0,1,32'h200,0,0,  0,0,0,1,32'h200);
        add(1,0,1,32'h200,1,D4, 1,D4,32'h200,0,32'h200);
        add(1,0,0,32'h200,0,0,  0,0,0,0,32'h200);
        // Clear and done in the same MISS cycle: fill, no pulse, then hit.
        add(1,0,1,32'h14,0,0,  0,0,0,1,32'h14);
        add(1,1,0,32'h14,1,D5, 0,0,0,0,32'h14);
        add(1,0,1,32'h14,0,0,  1,D5,32'h14,0,32'h14);
        add(1,0,0,32'h14,0,0,  0,0,0,0,32'h14);
        // Unaligned pc: low bits ignored for lookup and forced to 0 in instr_addr.
        add(1,0,1,32'h13,0,0,  1,D1,32'h10,0,32'h14);
        add(1,0,0,32'h13,0,0,  0,0,0,0,32'h14);

        // Reset state.
        rst_n = 1'b0;
        drive(1, 0, 0, 32'h0, 0, 32'h0);
        #12;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all("post-reset idle", 0, 0, 0, 0, 0);

        // Table.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rdy, vecs[i].rc, vecs[i].sf, vecs[i].pc, vecs[i].dn, vecs[i].dat);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].erd, vecs[i].eins,
                      vecs[i].eia, vecs[i].erq, vecs[i].era);
        end

        // rdy=0 for 4 cycles mid-MISS: nothing moves even with clear/new pc.
        drive(1, 0, 1, 32'h18, 0, 32'h0);
        tick();
        check_all("miss 0x18", 0, 0, 0, 1, 32'h18);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 32'h40, 0, 32'h0);
            tick();
            check_all($sformatf("frozen miss %0d", i), 0, 0, 0, 1, 32'h18);
        end
        drive(1, 0, 1, 32'h18, 1, D6);
        tick();
        check_all("refill 0x18", 1, D6, 32'h18, 0, 32'h18);
        drive(0, 0, 0, 32'h18, 0, 32'h0);
        tick();
        check_all("frozen pulse", 1, D6, 32'h18, 0, 32'h18);
        drive(1, 0, 0, 32'h18, 0, 32'h0);
        tick();
        check_all("pulse ends", 0, 0, 0, 0, 32'h18);

        // Async reset mid-MISS: immediate effect, every line invalidated.
        drive(1, 0, 1, 32'h1C, 0, 32'h0);
        tick();
        check_all("miss 0x1C", 0, 0, 0, 1, 32'h1C);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 1, 32'h10, 0, 32'h0);
        tick();
        check_all("0x10 invalid after reset", 0, 0, 0, 1, 32'h10);
        drive(1, 0, 1, 32'h10, 1, D1);
        tick();
        check_all("0x10 refilled", 1, D1, 32'h10, 0, 32'h10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
